// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit architectural register file with two combinational
// read ports, one write port, write-to-read bypass and a per-register busy
// scoreboard tracking in-flight results.
//
// Ports:
//   clk                        rising-edge clock
//   reset                      asynchronous, active-low
//   rs1Addr/rs2Addr  [4:0]     read addresses
//   rs1Data/rs2Data  [31:0]    read data (bypassed from the write port)
//   rs1Busy/rs2Busy            addressed register awaiting a result
//   regWrite, writeAddr, writeData   write port
//   issueValid, issueAddr      destination being marked pending
//   pendingCount     [5:0]     number of busy registers

// Reg32: one 32-bit storage word with load enable and active-high async clear.
module Reg32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

module reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1Addr,
  input  logic [4:0]  rs2Addr,
  output logic [31:0] rs1Data,
  output logic [31:0] rs2Data,
  output logic        rs1Busy,
  output logic        rs2Busy,
  input  logic        regWrite,
  input  logic [4:0]  writeAddr,
  input  logic [31:0] writeData,
  input  logic        issueValid,
  input  logic [4:0]  issueAddr,
  output logic [5:0]  pendingCount
);
  logic        rstHigh;
  logic        writeEn;
  logic        issueEn;
  logic [31:0] words [32];
  logic [31:0] busy;
  logic [31:0] busyNext;
  logic        setNew;
  logic        clearOld;

  assign rstHigh = ~reset;
  assign writeEn = regWrite && (writeAddr != 5'd0);
  assign issueEn = issueValid && (issueAddr != 5'd0);

  assign words[0] = '0;

  for (genvar i = 1; i < 32; i++) begin : gWords
    Reg32 uWord (
      .clk (clk),
      .rst (rstHigh),
      .en  (writeEn && (writeAddr == 5'(i))),
      .d   (writeData),
      .q   (words[i])
    );
  end

  // Reads are gated while reset is held so the bypass path cannot leak the
  // write port onto the operands.
  always_comb begin
    rs1Data = '0;
    rs2Data = '0;
    rs1Busy = 1'b0;
    rs2Busy = 1'b0;
    if (reset) begin
      rs1Data = (writeEn && (writeAddr == rs1Addr)) ? writeData : words[rs1Addr];
      rs2Data = (writeEn && (writeAddr == rs2Addr)) ? writeData : words[rs2Addr];
      rs1Busy = busy[rs1Addr] && !(writeEn && (writeAddr == rs1Addr));
      rs2Busy = busy[rs2Addr] && !(writeEn && (writeAddr == rs2Addr));
    end
  end

  // A new issue supersedes a writeback to the same register in the same cycle.
  always_comb begin
    busyNext = busy;
    if (writeEn)
      busyNext[writeAddr] = 1'b0;
    if (issueEn)
      busyNext[issueAddr] = 1'b1;
    busyNext[0] = 1'b0;
  end

  assign setNew   = issueEn && !busy[issueAddr];
  assign clearOld = writeEn && busy[writeAddr] &&
                    !(issueEn && (issueAddr == writeAddr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy         <= '0;
      pendingCount <= '0;
    end else begin
      busy         <= busyNext;
      pendingCount <= pendingCount + {5'd0, setNew} - {5'd0, clearOld};
    end
  end
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected values are queued when stimulus is
// applied and popped when the corresponding output is sampled.
module tb_reg_file;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1Addr, rs2Addr;
  logic [31:0] rs1Data, rs2Data;
  logic        rs1Busy, rs2Busy;
  logic        regWrite;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic        issueValid;
  logic [4:0]  issueAddr;
  logic [5:0]  pendingCount;

  int passCount = 0;
  int totalCount = 0;
  logic [31:0] expQ[$];

  always #5 clk = ~clk;

  reg_file dut (
    .clk          (clk),
    .reset        (reset),
    .rs1Addr      (rs1Addr),
    .rs2Addr      (rs2Addr),
    .rs1Data      (rs1Data),
    .rs2Data      (rs2Data),
    .rs1Busy      (rs1Busy),
    .rs2Busy      (rs2Busy),
    .regWrite     (regWrite),
    .writeAddr    (writeAddr),
    .writeData    (writeData),
    .issueValid   (issueValid),
    .issueAddr    (issueAddr),
    .pendingCount (pendingCount)
  );

  task automatic want(input logic [31:0] v);
    expQ.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    totalCount++;
    if (expQ.size() == 0) begin
      $error("FAIL %s: observed %h but no expected value queued", tag, obs);
    end else begin
      exp = expQ.pop_front();
      assert (obs === exp) passCount++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regWrite = 1'b0;
    issueValid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    rs1Addr = 5'd0; rs2Addr = 5'd0;
    regWrite = 1'b0; writeAddr = 5'd0; writeData = '0;
    issueValid = 1'b0; issueAddr = 5'd0;

    // reset state
    #2;
    want(32'd0); want(32'd0);
    #1;
    chk("resetPending", {26'd0, pendingCount});
    chk("resetBusy", {31'd0, rs1Busy});
    @(negedge clk); reset = 1'b1;

    // write r5, then asynchronous reset mid-cycle
    tick();
    regWrite = 1'b1; writeAddr = 5'd5; writeData = 32'hDEADBEEF;
    tick();
    idle(); rs1Addr = 5'd5;
    want(32'hDEADBEEF);
    #1 chk("r5Written", rs1Data);
    regWrite = 1'b1; writeData = 32'h11111111;
    #1 reset = 1'b0;
    want(32'd0); want(32'd0);
    #1;
    chk("r5AfterReset", rs1Data);
    chk("pendAfterReset", {26'd0, pendingCount});
    @(posedge clk); #2;
    idle(); reset = 1'b1;
    want(32'd0);
    #1 chk("resetDiscardsWrite", rs1Data);

    // write/read/bypass
    tick();
    regWrite = 1'b1; writeAddr = 5'd7; writeData = 32'h12345678;
    rs1Addr = 5'd7; rs2Addr = 5'd7;
    want(32'h12345678); want(32'h12345678);
    #1;
    chk("bypassRs1", rs1Data);
    chk("bypassRs2", rs2Data);
    tick();
    idle();
    want(32'h12345678); want(32'h12345678); want(32'd0);
    #1;
    chk("storedRs1", rs1Data);
    chk("storedRs2", rs2Data);
    chk("writeNoBusy", {26'd0, pendingCount});
    regWrite = 1'b1; writeAddr = 5'd0; writeData = 32'hFFFFFFFF; rs1Addr = 5'd0;
    want(32'd0);
    #1 chk("r0Bypass", rs1Data);
    tick();
    idle();
    want(32'd0);
    #1 chk("r0Stored", rs1Data);

    // scoreboard set and writeback clear
    issueValid = 1'b1; issueAddr = 5'd3;
    tick();
    idle(); rs1Addr = 5'd3;
    want(32'd1); want(32'd1);
    #1;
    chk("r3Busy", {31'd0, rs1Busy});
    chk("pendOne", {26'd0, pendingCount});
    regWrite = 1'b1; writeAddr = 5'd3; writeData = 32'hA5;
    want(32'd0); want(32'hA5);
    #1;
    chk("r3BusyClearComb", {31'd0, rs1Busy});
    chk("r3Bypass", rs1Data);
    tick();
    idle();
    want(32'd0);
    #1 chk("pendZero", {26'd0, pendingCount});

    // simultaneous set and clear on r9
    issueValid = 1'b1; issueAddr = 5'd9;
    tick();
    regWrite = 1'b1; writeAddr = 5'd9; writeData = 32'h1;
    tick();
    idle(); rs1Addr = 5'd9;
    want(32'h1); want(32'd1); want(32'd1);
    #1;
    chk("r9Data", rs1Data);
    chk("r9StillBusy", {31'd0, rs1Busy});
    chk("pendUnchanged", {26'd0, pendingCount});

    // saturation: r9 already busy, so all 31 end up busy
    for (int i = 1; i < 32; i++) begin
      issueValid = 1'b1; issueAddr = 5'(i);
      tick();
    end
    idle();
    want(32'd31);
    #1 chk("pend31", {26'd0, pendingCount});
    issueValid = 1'b1; issueAddr = 5'd4;
    tick();
    want(32'd31);
    #1 chk("reissueR4", {26'd0, pendingCount});
    issueAddr = 5'd0; rs1Addr = 5'd0;
    tick();
    idle();
    want(32'd31); want(32'd0);
    #1;
    chk("issueR0", {26'd0, pendingCount});
    chk("r0NeverBusy", {31'd0, rs1Busy});
    regWrite = 1'b1; writeAddr = 5'd1; writeData = 32'hCAFE;
    issueValid = 1'b1; issueAddr = 5'd2;
    tick();
    idle(); rs2Addr = 5'd1; rs1Addr = 5'd2;
    want(32'd30); want(32'd0); want(32'd1);
    #1;
    chk("pend30", {26'd0, pendingCount});
    chk("r1Cleared", {31'd0, rs2Busy});
    chk("r2Busy", {31'd0, rs1Busy});

    // reset while ten registers are busy
    reset = 1'b0;
    #2 reset = 1'b1;
    tick();
    for (int i = 10; i < 20; i++) begin
      issueValid = 1'b1; issueAddr = 5'(i);
      tick();
    end
    idle(); rs1Addr = 5'd12;
    want(32'd10); want(32'd1);
    #1;
    chk("pend10", {26'd0, pendingCount});
    chk("r12Busy", {31'd0, rs1Busy});
    #1 reset = 1'b0;
    want(32'd0); want(32'd0);
    #1;
    chk("pendAsyncClear", {26'd0, pendingCount});
    chk("busyAsyncClear", {31'd0, rs1Busy});
    @(negedge clk); reset = 1'b1;
    tick();
    want(32'd0);
    #1 chk("busyAfterRelease", {31'd0, rs1Busy});

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
